// File: rtl/game_flow_pkg.sv
// Shared types and the constant level table for the game flow sequencer.
package game_flow_pkg;

  typedef enum logic [2:0] {
    TITLE   = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    VICTORY = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [9:0] start_x;
    logic [9:0] start_y;
    logic [9:0] finish_x;
    logic [9:0] finish_y;
  } level_t;

  localparam int LEVEL_COUNT = 2;

  localparam level_t LEVEL0 = '{start_x: 10'd400, start_y: 10'd300,
                                finish_x: 10'd600, finish_y: 10'd400};
  localparam level_t LEVEL1 = '{start_x: 10'd100, start_y: 10'd100,
                                finish_x: 10'd700, finish_y: 10'd500};

  // Element 0 sits in the low bits, so LEVELS[i] is level i.
  localparam level_t [LEVEL_COUNT-1:0] LEVELS = {LEVEL1, LEVEL0};

  // Any index without a table entry falls back to level 0.
  function automatic level_t level_lookup(input int unsigned idx);
    level_t entry;
    case (idx)
      32'd1:   entry = LEVELS[1];
      default: entry = LEVELS[0];
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_debounce.sv
// Button synchronizer plus a frame-rate debouncer that reports debounced presses.
module frame_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchronizer for the asynchronous push button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive frame samples that disagree with the debounced level; flip on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (sample_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
          // Only a rising debounced edge is a press; it fires on the sample cycle itself.
          press_o = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Debounced level and agreement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: frame timing, title/load/play/victory flow and physics strobes.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int H_LAST           = 799,
  parameter int V_LAST           = 599,
  parameter int FRAMES_PER_DECEL = 5,
  parameter int VICTORY_FRAMES   = 180,
  parameter int DEBOUNCE_FRAMES  = 3,
  parameter int NUM_LEVELS       = 2,
  localparam int LVL_W           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [9:0]       h_coord,
  input  logic [9:0]       v_coord,
  input  logic             button_c,
  input  logic             victory_hit,
  output logic             end_of_frame,
  output logic             physics_step,
  output logic             decel_tick,
  output logic             load_level,
  output logic [LVL_W-1:0] level_sel,
  output logic [9:0]       start_x,
  output logic [9:0]       start_y,
  output logic [9:0]       finish_x,
  output logic [9:0]       finish_y,
  output state_t           game_state,
  output logic             show_victory
);

  localparam int STEP_W = (FRAMES_PER_DECEL > 1) ? $clog2(FRAMES_PER_DECEL) : 1;
  localparam int VIC_W  = (VICTORY_FRAMES > 1) ? $clog2(VICTORY_FRAMES) : 1;

  state_t              state_q;
  state_t              state_d;
  state_t              prev_state_q;
  logic                eof_q;
  logic                step_pend_q;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_d;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [STEP_W-1:0]   step_cnt_d;
  logic [VIC_W-1:0]    vic_cnt_q;
  logic [VIC_W-1:0]    vic_cnt_d;
  logic                btn_press;
  logic                step_active;
  logic                step_wrap;
  logic                vic_last;
  level_t              level_entry;

  frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (pixel_clk),
    .rst       (rst),
    .sample_i  (eof_q),
    .btn_raw_i (button_c),
    .press_o   (btn_press)
  );

  // A pending step only becomes a real step while still in PLAY.
  assign step_active = step_pend_q && (state_q == PLAY);
  assign step_wrap   = (step_cnt_q == STEP_W'(FRAMES_PER_DECEL - 1));
  assign vic_last    = (vic_cnt_q == VIC_W'(VICTORY_FRAMES - 1));

  // Frame strobe on the cycle after the last active pixel, and its one-cycle-delayed step request.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      eof_q       <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      eof_q       <= (h_coord == 10'(H_LAST)) && (v_coord == 10'(V_LAST));
      step_pend_q <= eof_q;
    end
  end

  // State register with level and counters.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q      <= TITLE;
      prev_state_q <= TITLE;
      level_q      <= '0;
      step_cnt_q   <= '0;
      vic_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_q;
      level_q      <= level_d;
      step_cnt_q   <= step_cnt_d;
      vic_cnt_q    <= vic_cnt_d;
    end
  end

  // Next-state logic: events are acted on in the cycle they occur.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    step_cnt_d = step_cnt_q;
    vic_cnt_d  = vic_cnt_q;
    unique case (state_q)
      TITLE: begin
        if (btn_press) begin
          level_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        step_cnt_d = '0;
        // Waiting for the frame strobe keeps the reload inside blanking.
        if (eof_q) state_d = PLAY;
      end
      PLAY: begin
        if (step_active) step_cnt_d = step_wrap ? '0 : step_cnt_q + STEP_W'(1);
        // A finish reached on this step beats a restart request.
        if (step_active && victory_hit) begin
          state_d   = VICTORY;
          vic_cnt_d = '0;
        end else if (btn_press && !victory_hit) begin
          state_d = LOAD;
        end
      end
      VICTORY: begin
        if (eof_q) vic_cnt_d = vic_cnt_q + VIC_W'(1);
        if ((eof_q && vic_last) || btn_press) begin
          if (level_q == LVL_W'(NUM_LEVELS - 1)) begin
            state_d = DONE;
          end else begin
            level_d = level_q + LVL_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        if (btn_press) begin
          level_d = '0;
          state_d = TITLE;
        end
      end
      default: state_d = TITLE;
    endcase
  end

  // Output decode: strobes and the victory-screen select.
  always_comb begin
    physics_step = step_active;
    decel_tick   = step_active && step_wrap;
    load_level   = (state_q == LOAD) && (prev_state_q != LOAD);
    show_victory = (state_q == VICTORY) || (state_q == DONE);
  end

  assign end_of_frame = eof_q;
  assign game_state   = state_q;
  assign level_sel    = level_q;

  assign level_entry = level_lookup(32'(level_q));
  assign start_x     = level_entry.start_x;
  assign start_y     = level_entry.start_y;
  assign finish_x    = level_entry.finish_x;
  assign finish_y    = level_entry.finish_y;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a cycle table for the main flow plus hand sequences.
module tb_game_flow_ctrl;
  import game_flow_pkg::*;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_coord = 10'd0;
  logic [9:0] v_coord = 10'd0;
  logic       button_c = 1'b0;
  logic       victory_hit = 1'b0;
  logic       end_of_frame, physics_step, decel_tick, load_level, show_victory;
  logic [0:0] level_sel;
  logic [9:0] start_x, start_y, finish_x, finish_y;
  state_t     game_state;

  game_flow_ctrl dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .h_coord      (h_coord),
    .v_coord      (v_coord),
    .button_c     (button_c),
    .victory_hit  (victory_hit),
    .end_of_frame (end_of_frame),
    .physics_step (physics_step),
    .decel_tick   (decel_tick),
    .load_level   (load_level),
    .level_sel    (level_sel),
    .start_x      (start_x),
    .start_y      (start_y),
    .finish_x     (finish_x),
    .finish_y     (finish_y),
    .game_state   (game_state),
    .show_victory (show_victory)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Observed outputs packed as {eof, step, decel, load, state[2:0], show, lvl}.
  logic [8:0] obs;
  assign obs = {end_of_frame, physics_step, decel_tick, load_level, game_state, show_victory, level_sel};

  typedef struct {
    bit     fr;
    bit     b;
    bit     vh;
    bit     eof;
    bit     st;
    bit     dc;
    bit     ld;
    state_t s;
    bit     sh;
    bit     lv;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   alt = 1'b0;

  function automatic vec_t mk(input bit fr, input bit b, input bit vh, input bit eof, input bit st,
                              input bit dc, input bit ld, input state_t s, input bit sh, input bit lv);
    vec_t v;
    v.fr = fr; v.b = b; v.vh = vh; v.eof = eof; v.st = st;
    v.dc = dc; v.ld = ld; v.s = s; v.sh = sh; v.lv = lv;
    return v;
  endfunction

  function automatic logic [8:0] expect_bits(input vec_t v);
    return {v.eof, v.st, v.dc, v.ld, v.s, v.sh, v.lv};
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Apply one cycle of inputs; outputs are observed 1 ns after the edge.
  // Non-frame cycles alternate between matching only h or only v against the last pixel.
  task automatic tick(input bit fr, input bit b, input bit vh);
    if (fr) begin
      h_coord = 10'd799;
      v_coord = 10'd599;
    end else begin
      alt = ~alt;
      h_coord = alt ? 10'd799 : 10'd0;
      v_coord = alt ? 10'd0 : 10'd599;
    end
    button_c    = b;
    victory_hit = vh;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic frame(input bit b);
    tick(1'b1, b, 1'b0);
    tick(1'b0, b, 1'b0);
  endtask

  // Hold the button level through the synchronizer and three frame samples.
  task automatic hold_btn(input bit b);
    tick(1'b0, b, 1'b0);
    tick(1'b0, b, 1'b0);
    repeat (3) frame(b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit bad;

    // Main flow table: TITLE idle, press, LOAD, PLAY steps/decel, 2-frame glitch, victory.
    tbl.push_back(mk(0,0,0, 0,0,0,0, TITLE,  0,0)); // 0
    tbl.push_back(mk(1,0,0, 1,0,0,0, TITLE,  0,0)); // 1 frame strobe
    tbl.push_back(mk(0,0,0, 0,0,0,0, TITLE,  0,0)); // 2 no step in TITLE
    tbl.push_back(mk(0,0,0, 0,0,0,0, TITLE,  0,0)); // 3
    tbl.push_back(mk(0,1,0, 0,0,0,0, TITLE,  0,0)); // 4 button down
    tbl.push_back(mk(0,1,0, 0,0,0,0, TITLE,  0,0)); // 5
    tbl.push_back(mk(1,1,0, 1,0,0,0, TITLE,  0,0)); // 6 sample 1
    tbl.push_back(mk(0,1,0, 0,0,0,0, TITLE,  0,0)); // 7
    tbl.push_back(mk(1,1,0, 1,0,0,0, TITLE,  0,0)); // 8 sample 2
    tbl.push_back(mk(0,1,0, 0,0,0,0, TITLE,  0,0)); // 9
    tbl.push_back(mk(1,1,0, 1,0,0,0, TITLE,  0,0)); // 10 sample 3 -> press
    tbl.push_back(mk(0,1,0, 0,0,0,1, LOAD,   0,0)); // 11 load strobe
    tbl.push_back(mk(0,1,0, 0,0,0,0, LOAD,   0,0)); // 12
    tbl.push_back(mk(1,0,0, 1,0,0,0, LOAD,   0,0)); // 13 eof in LOAD
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 14 step 1
    tbl.push_back(mk(0,0,0, 0,0,0,0, PLAY,   0,0)); // 15
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 16
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 17 step 2
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 18
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 19 step 3
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 20
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 21 step 4
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 22
    tbl.push_back(mk(0,0,0, 0,1,1,0, PLAY,   0,0)); // 23 step 5 decel
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 24
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 25 step 6
    tbl.push_back(mk(0,1,0, 0,0,0,0, PLAY,   0,0)); // 26 short press begins
    tbl.push_back(mk(0,1,0, 0,0,0,0, PLAY,   0,0)); // 27
    tbl.push_back(mk(1,1,0, 1,0,0,0, PLAY,   0,0)); // 28 sample 1
    tbl.push_back(mk(0,1,0, 0,1,0,0, PLAY,   0,0)); // 29 step 7
    tbl.push_back(mk(1,1,0, 1,0,0,0, PLAY,   0,0)); // 30 sample 2
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 31 step 8, released
    tbl.push_back(mk(0,0,0, 0,0,0,0, PLAY,   0,0)); // 32
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 33 sample resets count
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 34 step 9, still PLAY
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 35
    tbl.push_back(mk(0,0,0, 0,1,1,0, PLAY,   0,0)); // 36 step 10 decel
    tbl.push_back(mk(1,0,0, 1,0,0,0, PLAY,   0,0)); // 37
    tbl.push_back(mk(0,0,0, 0,1,0,0, PLAY,   0,0)); // 38 step 11
    tbl.push_back(mk(0,0,1, 0,0,0,0, VICTORY,1,0)); // 39 hit on step

    // Reset state.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("reset_outputs", int'(obs), 0);
    chk("reset_start_x", int'(start_x), 400);
    chk("reset_finish_y", int'(finish_y), 400);
    rst = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].fr, tbl[i].b, tbl[i].vh);
      chk($sformatf("row%0d", i), int'(obs), int'(expect_bits(tbl[i])));
    end
    chk("lvl0_start_x", int'(start_x), 400);
    chk("lvl0_start_y", int'(start_y), 300);
    chk("lvl0_finish_x", int'(finish_x), 600);

    // Victory screen holds for 180 frames then advances to level 1.
    bad = 1'b0;
    for (int f = 0; f < 179; f++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (physics_step || load_level || game_state != VICTORY || !show_victory) bad = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      if (physics_step || load_level || game_state != VICTORY || !show_victory) bad = 1'b1;
    end
    chk("victory_hold_clean", int'(bad), 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("victory_last_frame_state", int'(game_state), int'(VICTORY));
    tick(1'b0, 1'b0, 1'b0);
    chk("victory_exit_state", int'(game_state), int'(LOAD));
    chk("victory_exit_load", int'(load_level), 1);
    chk("victory_exit_step_suppressed", int'(physics_step), 0);
    chk("lvl1_sel", int'(level_sel), 1);
    chk("lvl1_finish_x", int'(finish_x), 700);
    chk("lvl1_finish_y", int'(finish_y), 500);
    chk("lvl1_start_x", int'(start_x), 100);
    tick(1'b0, 1'b0, 1'b0);
    chk("load_single_cycle", int'(load_level), 0);

    // Level 1: play, win, exit by button into DONE, then back to TITLE.
    frame(1'b0);
    chk("lvl1_play_step", int'({game_state == PLAY, physics_step}), 3);
    tick(1'b0, 1'b0, 1'b1);
    chk("lvl1_victory", int'(game_state), int'(VICTORY));
    hold_btn(1'b1);
    chk("done_state", int'(game_state), int'(DONE));
    chk("done_show", int'({show_victory, level_sel}), 3);
    hold_btn(1'b0);
    chk("done_after_release", int'(game_state), int'(DONE));
    hold_btn(1'b1);
    chk("title_from_done", int'(obs), 0);

    // Restart from PLAY reloads the same level and swallows the pending step.
    hold_btn(1'b0);
    hold_btn(1'b1);
    chk("title_press_load", int'({game_state == LOAD, load_level, level_sel}), 6);
    frame(1'b1);
    chk("enter_play", int'(game_state), int'(PLAY));
    hold_btn(1'b0);
    hold_btn(1'b1);
    chk("restart_state", int'(game_state), int'(LOAD));
    chk("restart_strobes", int'({load_level, physics_step, level_sel}), 4);
    frame(1'b1);
    hold_btn(1'b0);

    // Press and victory_hit together: victory wins.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    frame(1'b1);
    frame(1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("press_with_hit_stays_play", int'({game_state == PLAY, physics_step}), 3);
    tick(1'b0, 1'b1, 1'b1);
    chk("hit_beats_restart", int'(game_state), int'(VICTORY));
    chk("hit_no_load", int'(load_level), 0);

    // Leave victory on level 0 via the button, reach PLAY on level 1, reset mid-frame.
    hold_btn(1'b0);
    hold_btn(1'b1);
    chk("victory_btn_exit", int'({game_state == LOAD, level_sel}), 3);
    frame(1'b1);
    tick(1'b1, 1'b1, 1'b0);
    chk("pre_reset_play_eof", int'({game_state == PLAY, end_of_frame}), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'(obs), 0);
    chk("async_reset_start_x", int'(start_x), 400);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk($sformatf("post_reset_quiet%0d", k), int'(obs), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
